// File: rtl/hpdmc_pkg.sv
// Shared types and constants for the hpdmc write-data path.
package hpdmc_pkg;

  localparam int DDR_W = 16;
  localparam int BUS_W = 32;
  localparam int BE_W  = BUS_W / 8;

  // DM pin level that suppresses a byte lane
  localparam logic DM_MASKED = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_PRE   = 3'd2,
    ST_BURST = 3'd3,
    ST_POST  = 3'd4
  } state_t;

  typedef struct packed {
    logic [BE_W-1:0]  be;
    logic [BUS_W-1:0] data;
  } wr_word_t;

endpackage

// File: rtl/hpdmc_wrfifo.sv
// Show-ahead write FIFO: head is valid combinationally whenever level != 0.
// Callers gate push on !full and pop on !empty; the FIFO does not re-check.
module hpdmc_wrfifo
  import hpdmc_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  wr_word_t      push_word,
  input  logic          pop,
  output wr_word_t      head,
  output logic [LW-1:0] level
);

  wr_word_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/hpdmc_wrdata.sv
// Write-data stager: buffers bus words, then after WR_LAT emits DQS preamble, BURST beats, postamble.
// All pad-side outputs are registered from the next state; wr_ready drops only when the FIFO is full.
module hpdmc_wrdata
  import hpdmc_pkg::*;
#(
  parameter int BURST      = 4,
  parameter int WR_LAT     = 1,
  parameter int FIFO_DEPTH = 8,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [BUS_W-1:0] wr_data,
  input  logic [BE_W-1:0]  wr_be,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             write_start,
  output logic             busy,
  output logic [DDR_W-1:0] d0,
  output logic [DDR_W-1:0] d1,
  output logic [1:0]       dm0,
  output logic [1:0]       dm1,
  output logic             dq_oe,
  output logic             dqs_oe,
  output logic             dqs_d0,
  output logic             dqs_d1,
  output logic [LVL_W-1:0] level,
  output logic             underrun,
  input  logic             underrun_clr
);

  localparam int BEAT_W = $clog2(BURST + 1);
  localparam int LAT_W  = $clog2(WR_LAT + 1);
  localparam logic [1:0] DM_ALL = {2{DM_MASKED}};

  state_t            state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  wr_word_t          in_word, head;
  logic              fifo_empty, push, pop, underrun_evt;

  assign in_word      = '{be: wr_be, data: wr_data};
  assign wr_ready     = (level != LVL_W'(FIFO_DEPTH));
  assign fifo_empty   = (level == '0);
  assign push         = wr_valid && wr_ready;
  assign pop          = (state_nxt == ST_BURST) && !fifo_empty;
  assign underrun_evt = (state_nxt == ST_BURST) && fifo_empty;
  assign busy         = (state != ST_IDLE);

  hpdmc_wrfifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (push),
    .push_word (in_word),
    .pop       (pop),
    .head      (head),
    .level     (level)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
      beat    <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      beat    <= beat_nxt;
    end
  end

  // POST accepts a new start so back-to-back bursts share one DQS low cycle
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    beat_nxt    = beat;
    unique case (state)
      ST_IDLE, ST_POST: begin
        state_nxt = ST_IDLE;
        if (write_start) begin
          if (WR_LAT == 1) begin
            state_nxt = ST_PRE;
          end else begin
            state_nxt   = ST_WAIT;
            lat_cnt_nxt = LAT_W'(WR_LAT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (lat_cnt <= LAT_W'(1)) state_nxt = ST_PRE;
        else                      lat_cnt_nxt = lat_cnt - 1'b1;
      end
      ST_PRE: begin
        state_nxt = ST_BURST;
        beat_nxt  = '0;
      end
      ST_BURST: begin
        if (beat == BEAT_W'(BURST - 1)) state_nxt = ST_POST;
        else                            beat_nxt  = beat + 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are loaded on the edge entering each state; d0/d1 hold outside bursts
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      d0       <= '0;
      d1       <= '0;
      dm0      <= DM_ALL;
      dm1      <= DM_ALL;
      dq_oe    <= 1'b0;
      dqs_oe   <= 1'b0;
      dqs_d0   <= 1'b0;
      dqs_d1   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      dq_oe  <= 1'b0;
      dqs_oe <= 1'b0;
      dqs_d0 <= 1'b0;
      dqs_d1 <= 1'b0;
      dm0    <= DM_ALL;
      dm1    <= DM_ALL;
      unique case (state_nxt)
        ST_PRE, ST_POST: dqs_oe <= 1'b1;
        ST_BURST: begin
          dqs_oe <= 1'b1;
          dqs_d0 <= 1'b1;
          dq_oe  <= 1'b1;
          if (fifo_empty) begin
            d0 <= '0;
            d1 <= '0;
          end else begin
            d0  <= head.data[BUS_W-1:DDR_W];
            d1  <= head.data[DDR_W-1:0];
            // XOR with the masked level turns an enable into the pin's mask sense
            dm0 <= head.be[3:2] ^ DM_ALL;
            dm1 <= head.be[1:0] ^ DM_ALL;
          end
        end
        default: ;
      endcase
      if (underrun_evt)      underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hpdmc_wrdata.sv
// Scoreboard bench for hpdmc_wrdata at default parameters (BURST=4, WR_LAT=1, FIFO_DEPTH=8).
module tb_hpdmc_wrdata;

  localparam int BURST = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        write_start = 1'b0;
  logic        busy;
  logic [15:0] d0, d1;
  logic [1:0]  dm0, dm1;
  logic        dq_oe, dqs_oe, dqs_d0, dqs_d1;
  logic [3:0]  level;
  logic        underrun;
  logic        underrun_clr = 1'b0;

  always #5 sys_clk = ~sys_clk;

  hpdmc_wrdata dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .wr_data      (wr_data),
    .wr_be        (wr_be),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .write_start  (write_start),
    .busy         (busy),
    .d0           (d0),
    .d1           (d1),
    .dm0          (dm0),
    .dm1          (dm1),
    .dq_oe        (dq_oe),
    .dqs_oe       (dqs_oe),
    .dqs_d0       (dqs_d0),
    .dqs_d1       (dqs_d1),
    .level        (level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  typedef struct packed {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  dm0;
    logic [1:0]  dm1;
  } beat_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [35:0] model_q[$];
  beat_t       exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic [3:0] be);
    wr_data  = d;
    wr_be    = be;
    wr_valid = 1'b1;
    if (wr_ready) model_q.push_back({be, d});
    tick();
    wr_valid = 1'b0;
  endtask

  // Reserve the beats this burst will produce, then pulse write_start; returns in PRE
  task automatic start();
    logic [35:0] w;
    beat_t       b;
    for (int i = 0; i < BURST; i++) begin
      if (model_q.size() != 0) begin
        w = model_q.pop_front();
        b = '{d0: w[31:16], d1: w[15:0], dm0: ~w[35:34], dm1: ~w[33:32]};
      end else begin
        b = '{d0: 16'h0, d1: 16'h0, dm0: 2'b11, dm1: 2'b11};
      end
      exp_q.push_back(b);
    end
    write_start = 1'b1;
    tick();
    write_start = 1'b0;
  endtask

  task automatic run_burst(input string tg);
    chk({tg, "_pre_dqs_oe"}, dqs_oe, 1);
    chk({tg, "_pre_dq_oe"}, dq_oe, 0);
    chk({tg, "_pre_busy"}, busy, 1);
    for (int i = 0; i < BURST; i++) begin
      tick();
      chk({tg, "_burst_dq_oe"}, dq_oe, 1);
      chk({tg, "_burst_dqs"}, {dqs_oe, dqs_d0, dqs_d1}, 3'b110);
    end
    tick();
    chk({tg, "_post_dqs"}, {dqs_oe, dqs_d0, dqs_d1}, 3'b100);
    chk({tg, "_post_dq_oe"}, dq_oe, 0);
    tick();
    chk({tg, "_idle_busy"}, busy, 0);
    chk({tg, "_idle_en"}, {dqs_oe, dq_oe}, 2'b00);
    chk({tg, "_idle_dm"}, {dm0, dm1}, 4'hF);
  endtask

  always @(negedge sys_clk) begin
    beat_t e;
    if (sys_rst_n && dq_oe) begin
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_d0", d0, e.d0);
        chk("beat_d1", d1, e.d1);
        chk("beat_dm0", dm0, e.dm0);
        chk("beat_dm1", dm1, e.dm1);
      end
    end
  end

  initial begin
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_d0d1", {d0, d1}, 32'h0);
    chk("rst_dm", {dm0, dm1}, 4'hF);
    chk("rst_en", {dq_oe, dqs_oe, dqs_d0, dqs_d1}, 4'h0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_level", level, 0);
    chk("rst_wr_ready", wr_ready, 1);
    sys_rst_n = 1'b1;
    tick();

    // Basic burst
    push_word(32'h11112222, 4'hF);
    push_word(32'h33334444, 4'hF);
    push_word(32'h55556666, 4'hF);
    push_word(32'h77778888, 4'hF);
    chk("basic_level4", level, 4);
    start();
    run_burst("basic");
    chk("basic_level0", level, 0);
    chk("basic_hold", {d0, d1}, 32'h77778888);
    chk("basic_underrun", underrun, 0);

    // Byte masking
    push_word(32'hAABBCCDD, 4'b1001);
    push_word(32'h12345678, 4'b0110);
    push_word(32'hDEADBEEF, 4'b0000);
    push_word(32'h0F0F0F0F, 4'b1111);
    start();
    run_burst("mask");

    // Underrun: two words for a four-beat burst
    push_word(32'hCAFE0001, 4'hF);
    push_word(32'hCAFE0002, 4'b1100);
    start();
    run_burst("urun");
    chk("urun_set", underrun, 1);
    chk("urun_dz", {d0, d1}, 32'h0);
    tick();
    chk("urun_sticky", underrun, 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("urun_clr", underrun, 0);

    // Full FIFO and back-pressure
    for (int i = 0; i < 8; i++) push_word(32'hF0000000 | 32'(i), 4'(i + 3));
    wr_data  = 32'h99999999;
    wr_be    = 4'b0101;
    wr_valid = 1'b1;
    chk("full_level", level, 8);
    chk("full_rdy", wr_ready, 0);
    tick();
    chk("full_held", level, 8);
    start();
    chk("full_pre_level", level, 8);
    chk("full_pre_rdy", wr_ready, 0);
    tick();
    chk("full_pop1_level", level, 7);
    chk("full_pop1_rdy", wr_ready, 1);
    model_q.push_back({4'b0101, 32'h99999999});
    tick();
    wr_valid = 1'b0;
    chk("full_pushpop", level, 7);
    tick();
    tick();
    chk("full_end_level", level, 5);
    tick();
    tick();
    chk("full_idle", busy, 0);
    chk("full_idle_level", level, 5);

    // Reset mid-burst discards everything
    start();
    tick();
    @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_dq_oe", dq_oe, 0);
    chk("midrst_dm", {dm0, dm1}, 4'hF);
    chk("midrst_level", level, 0);
    exp_q.delete();
    model_q.delete();
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_rdy", wr_ready, 1);

    // Back-to-back with an ignored start mid-burst
    for (int i = 0; i < 8; i++) push_word(32'hB0B00000 + 32'(i * 17), 4'(15 - i));
    start();
    tick();
    tick();
    write_start = 1'b1;
    chk("b2b_t3_busy", busy, 1);
    tick();
    write_start = 1'b0;
    tick();
    tick();
    chk("b2b_post_dqs", {dqs_oe, dqs_d0}, 2'b10);
    chk("b2b_post_dq_oe", dq_oe, 0);
    start();
    run_burst("b2b2");
    chk("b2b_level", level, 0);

    chk("exp_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hpdmc_wrdata.md
Name: hpdmc_wrdata

Overview:
Write-data staging stage of the 16-bit DDR SDRAM controller. It sits directly upstream of the 16-bit output DDR register bank. It buffers 32-bit write words from the bus side in a small FIFO. When the command sequencer issues a write, it waits the write latency and then presents each word as two 16-bit halves per clock. It also drives the data masks, the DQ/DQS output enables and the DQS preamble/burst/postamble pattern.

Parameters:
BURST, 4, words per write burst (one word per sys_clk = 2 DDR beats); range 1..8
WR_LAT, 1, sys_clk cycles from write_start to DQS preamble; minimum 1
FIFO_DEPTH, 8, write FIFO depth in words; power of 2, >= BURST

Ports:
sys_clk  in  1  system clock; same clock as C0 of the DDR output bank
sys_rst_n  in  1  reset, asynchronous assert, active-low
wr_data  in  32  bus write word; [31:16] is the first DDR beat
wr_be  in  4  byte enables, active-high; [3:2] go with [31:16]
wr_valid  in  1  wr_data/wr_be valid
wr_ready  out  1  FIFO can accept a word
write_start  in  1  one-cycle pulse from the sequencer, same cycle as the WRITE command
busy  out  1  burst sequence in progress (state != IDLE)
d0  out  16  to DDR bank D0 (rising-edge beat)
d1  out  16  to DDR bank D1 (falling-edge beat)
dm0  out  2  mask for the d0 beat, active-high = masked
dm1  out  2  mask for the d1 beat
dq_oe  out  1  DQ/DM tristate enable
dqs_oe  out  1  DQS tristate enable
dqs_d0  out  1  DQS DDR bank D0
dqs_d1  out  1  DQS DDR bank D1
level  out  log2(FIFO_DEPTH)+1  FIFO occupancy
underrun  out  1  sticky; set when a burst word was needed but the FIFO was empty
underrun_clr  in  1  clears underrun

Behaviour:
- Clock and reset: a single clock, sys_clk. sys_rst_n is asynchronous and active-low.
- Reset values: d0=d1=0, dm0=dm1=2'b11, dq_oe=dqs_oe=dqs_d0=dqs_d1=0, busy=0, underrun=0, FIFO empty (level=0, wr_ready=1), state IDLE.
- Reset mid-burst aborts immediately; FIFO contents are discarded.
- FIFO behaviour:
  - Push when wr_valid && wr_ready. wr_ready = (level != FIFO_DEPTH).
  - Pop only in BURST cycles. Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, WAIT, PRE, BURST, POST.
  - IDLE: write_start goes to PRE if WR_LAT=1, else to WAIT with counter WR_LAT-1.
  - WAIT: decrement the counter; go to PRE when it reaches 1.
  - PRE: lasts 1 cycle, then BURST with beat counter 0.
  - BURST: lasts BURST cycles, then POST.
  - POST: lasts 1 cycle, then IDLE.
  - With WR_LAT=1 and a pulse at cycle T: PRE at T+1, BURST at T+2..T+1+BURST, POST at T+2+BURST.
- Outputs are all registered and reflect the current state:
  - PRE: dqs_oe=1, dqs_d0=dqs_d1=0, dq_oe=0.
  - BURST: dqs_oe=1, dqs_d0=1, dqs_d1=0, dq_oe=1. The head word is popped on the edge entering each BURST cycle.
    - d0 = word[31:16], d1 = word[15:0].
    - dm0 = ~be[3:2], dm1 = ~be[1:0].
  - POST: dqs_oe=1, dqs_d0=dqs_d1=0, dq_oe=0.
  - IDLE/WAIT: all enables 0, dm=2'b11, d0/d1 hold their last value.
- Underrun: if the FIFO is empty when a BURST word is due, output d0=d1=0 and dm0=dm1=2'b11 for that cycle, set underrun, and continue the burst. No pop occurs.
- Ignored write_start: a write_start while busy=1 is ignored; the sequencer must respect busy.
  - Exception: write_start in the POST cycle is accepted. The next state is PRE (or WAIT), giving back-to-back bursts with a single DQS low cycle.
- Underrun precedence: underrun_clr and a new underrun event in the same cycle leave underrun set.

Decomposition:
- Package hpdmc_pkg holds:
  - the state encoding constants (IDLE=0, WAIT=1, PRE=2, BURST=3, POST=4);
  - the DDR data width (16) and bus width (32);
  - the mask polarity constant DM_MASKED=1.
- One sub-module: hpdmc_wrfifo, a synchronous show-ahead FIFO (36-bit entries: data+be, parameter depth, level output).
- The FSM and output registers live in hpdmc_wrdata.

Test Plan:
- Reset mid-burst: assert sys_rst_n=0 during BURST -> same cycle dq_oe=0, dm0=dm1=2'b11, level=0; after release busy=0 and wr_ready=1.
- Basic burst: prefill 4 words 0x11112222/0x33334444/0x55556666/0x77778888 with be=4'hF, pulse write_start at T (WR_LAT=1):
  - T+1: PRE;
  - T+2..T+5: d0/d1 = 1111/2222 ... 7777/8888, dq_oe=1, dm=0;
  - T+6: POST, dqs_oe=1, dq_oe=0;
  - level ends at 0.
- Byte masking: word 0xAABBCCDD with be=4'b1001 -> d0=AABB, dm0=2'b01, d1=CCDD, dm1=2'b10.
- Underrun: prefill only 2 words, then start -> beats 3-4 show dm=2'b11, d=0; underrun=1 until underrun_clr pulse.
- Full/back-pressure: push 9 words with FIFO_DEPTH=8 -> wr_ready=0 at level=8 and the 9th is held. Then start a burst -> wr_ready returns 1 the cycle after the first pop, and push+pop holds level.
- Back-to-back: write_start at T and again at T+6 (POST) -> second PRE at T+7, second BURST T+8..T+11. A write_start at T+3 is ignored.
